flash_encoder_sync: RTL and testbench
=====================================

Name: flash_encoder_sync

Overview:
Clocked, parametrised successor to the flash-ADC thermometer encoder. It samples the comparator thermometer bus on a strobe and removes single-bit bubbles with a 3-input majority filter. It then priority-encodes the corrected bus to binary and optionally block-averages 2^AVG_LOG2 conversions. It sits between the comparator bank and the digital back-end of the ADC.

Parameters:
N_BITS, 4, output code width; thermometer width THERM_W = 2**N_BITS
AVG_LOG2, 2, log2 of the averaging window (0 = no averaging)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_en  input  1  strobe: capture therm this cycle
avg_clear  input  1  synchronous clear of the averaging window
therm  input  THERM_W  comparator thermometer bus, bit i = comparator i
code  output  N_BITS  encoded conversion result
code_valid  output  1  one-cycle pulse: code, over_range and bubble_err are new
over_range  output  1  corrected therm[THERM_W-1] set
bubble_err  output  1  correction changed at least one bit
avg_code  output  N_BITS  block-average result
avg_valid  output  1  one-cycle pulse: avg_code is new

Behaviour:
- Reset (rst_n=0, asynchronous): all registers 0, including code, code_valid, over_range, bubble_err, avg_code, avg_valid, the pipeline valid bits, the accumulator and the window counter. Outputs are held at 0 until the first result after release.
- Stage 1, cycle T with sample_en=1: s1 <= therm and s1_v <= 1. With sample_en=0: s1_v <= 0 and s1 holds.
- Stage 2, at cycle T+1, combinational on s1:
  - Bubble correction: c[i] = maj(s1[i-1], s1[i], s1[i+1]). Out-of-range neighbours are fixed: s1[-1] = 1 and s1[THERM_W] = 0.
  - Priority encode: code_n = highest index i in 1..THERM_W-1 with c[i]=1, else 0. Bit 0 never contributes, so therm=0 and therm=1 both give code 0.
  - Registered at the end of T+1 only if s1_v: code, over_range <= c[THERM_W-1], bubble_err <= (c != s1). code_valid <= s1_v.
- Latency: sample_en at T gives code_valid high during cycle T+2 only.
- Back-to-back sample_en gives one result per cycle. Gaps in sample_en give gaps in code_valid. Non-valid cycles hold code, over_range and bubble_err unchanged.
- Averaging, AVG_LOG2 > 0:
  - acc has N_BITS+AVG_LOG2 bits; cnt has AVG_LOG2 bits.
  - On each code_valid cycle: acc += code, cnt += 1.
  - When cnt = 2^AVG_LOG2-1 on a code_valid cycle: avg_code <= (acc+code) >> AVG_LOG2 (truncating), avg_valid <= 1 on the next cycle, acc <= 0, cnt <= 0.
  - avg_valid is a single-cycle pulse. avg_code holds between pulses.
- Averaging, AVG_LOG2 = 0: avg_code <= code and avg_valid <= code_valid, i.e. delayed one cycle.
- avg_clear=1: acc <= 0, cnt <= 0, no avg_valid is produced.
  - If code_valid occurs in the same cycle, that sample starts the new window: acc <= code, cnt <= 1.
  - avg_clear does not affect the encode pipeline.
- Reset mid-operation: in-flight samples and the partial window are discarded. There is no spurious code_valid or avg_valid after release.
- Overflow: acc never overflows by construction (max sum (2^N_BITS-1)*2^AVG_LOG2).

Test Plan:
1. Clean encode: N_BITS=4, sample_en pulse with therm=16'h00FF at T -> code=7, code_valid=1 only at T+2, over_range=0, bubble_err=0.
2. Bubble removal: therm=16'h00DF -> corrected 16'h00FF, code=7, bubble_err=1. Isolated high bit: therm=16'h0401 -> code=0, bubble_err=1.
3. Range ends: therm=16'hFFFF -> code=15, over_range=1. therm=16'h0000 -> code=0, over_range=0. therm=16'h0001 -> code=0.
4. Averaging, AVG_LOG2=2: four consecutive samples giving codes 3,4,5,6 -> avg_code=4 (18>>2), avg_valid pulses once, one cycle after the 4th code_valid. The next window starts from acc=0.
5. avg_clear mid-window, after 2 samples, coincident with the 3rd code_valid: no avg_valid, and the window completes 3 samples later. Separately, sample_en with gaps: code_valid pattern mirrors sample_en delayed 2 cycles.
6. Assert rst_n=0 for one cycle while 2 samples are in flight and the window is half full. After release: no code_valid or avg_valid until new samples arrive, all outputs 0, and the first full window averages correctly.

Source files
------------

// File: rtl/flash_encoder_sync_if.sv
// rtl/flash_encoder_sync_if.sv - comparator-side and result-side signal bundle of the flash encoder
interface flash_encoder_sync_if #(
    parameter int N_BITS = 4
);
    localparam int THERM_W = 2 ** N_BITS;

    logic               sample_en;
    logic               avg_clear;
    logic [THERM_W-1:0] therm;
    logic [N_BITS-1:0]  code;
    logic               code_valid;
    logic               over_range;
    logic               bubble_err;
    logic [N_BITS-1:0]  avg_code;
    logic               avg_valid;

    modport master (
        output sample_en, avg_clear, therm,
        input  code, code_valid, over_range, bubble_err, avg_code, avg_valid
    );

    modport slave (
        input  sample_en, avg_clear, therm,
        output code, code_valid, over_range, bubble_err, avg_code, avg_valid
    );
endinterface

// File: rtl/flash_encoder_sync.sv
// rtl/flash_encoder_sync.sv - sampled thermometer-to-binary encoder with bubble filter and block averager
module flash_encoder_sync #(
    parameter int N_BITS   = 4,
    parameter int AVG_LOG2 = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    flash_encoder_sync_if.slave bus
);
    localparam int THERM_W = 2 ** N_BITS;

    logic [THERM_W-1:0] s1;
    logic               s1_v;
    logic [THERM_W+1:0] ext;
    logic [THERM_W-1:0] c;
    logic [N_BITS-1:0]  code_n;

    logic [N_BITS-1:0]  code_q;
    logic               code_valid_q;
    logic               over_range_q;
    logic               bubble_err_q;
    logic [N_BITS-1:0]  avg_code_q;
    logic               avg_valid_q;

    // Stage 1: capture the comparator bus on the strobe; hold it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= bus.sample_en;
            if (bus.sample_en) begin
                s1 <= bus.therm;
            end
        end
    end

    // Fixed neighbours beyond the ends: below bit 0 reads 1, above the top reads 0
    assign ext = {1'b0, s1, 1'b1};

    // 3-input majority over each bit and its two neighbours removes single-bit bubbles
    always_comb begin
        c = '0;
        for (int i = 0; i < THERM_W; i++) begin
            c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    // Highest set corrected bit wins; bit 0 is excluded so an all-zero or bit-0-only bus is code 0
    always_comb begin
        code_n = '0;
        for (int i = 1; i < THERM_W; i++) begin
            if (c[i]) begin
                code_n = N_BITS'(i);
            end
        end
    end

    // Stage 2: register the conversion result; flags hold on non-valid cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q       <= '0;
            code_valid_q <= 1'b0;
            over_range_q <= 1'b0;
            bubble_err_q <= 1'b0;
        end else begin
            code_valid_q <= s1_v;
            if (s1_v) begin
                code_q       <= code_n;
                over_range_q <= c[THERM_W-1];
                bubble_err_q <= (c != s1);
            end
        end
    end

    generate
        if (AVG_LOG2 > 0) begin : g_avg
            localparam int ACC_W = N_BITS + AVG_LOG2;

            logic [ACC_W-1:0]    acc;
            logic [ACC_W-1:0]    sum;
            logic [AVG_LOG2-1:0] cnt;

            // Running sum including the result on the bus this cycle; cannot overflow ACC_W
            assign sum = acc + ACC_W'(code_q);

            // Block averager: accumulate 2^AVG_LOG2 results, emit the truncated mean, restart
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc         <= '0;
                    cnt         <= '0;
                    avg_code_q  <= '0;
                    avg_valid_q <= 1'b0;
                end else begin
                    avg_valid_q <= 1'b0;
                    if (bus.avg_clear) begin
                        // A result arriving with the clear becomes the first of the new window
                        if (code_valid_q) begin
                            acc <= ACC_W'(code_q);
                            cnt <= AVG_LOG2'(1);
                        end else begin
                            acc <= '0;
                            cnt <= '0;
                        end
                    end else if (code_valid_q) begin
                        if (cnt == '1) begin
                            avg_code_q  <= sum[ACC_W-1:AVG_LOG2];
                            avg_valid_q <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + AVG_LOG2'(1);
                        end
                    end
                end
            end
        end else begin : g_no_avg
            // Window of one: the average is the result delayed by a cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    avg_code_q  <= '0;
                    avg_valid_q <= 1'b0;
                end else begin
                    avg_code_q  <= code_q;
                    avg_valid_q <= code_valid_q;
                end
            end
        end
    endgenerate

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.over_range = over_range_q;
    assign bus.bubble_err = bubble_err_q;
    assign bus.avg_code   = avg_code_q;
    assign bus.avg_valid  = avg_valid_q;
endmodule

// File: tb/tb_flash_encoder_sync.sv
// tb/tb_flash_encoder_sync.sv - scoreboard bench for flash_encoder_sync
module tb_flash_encoder_sync;
    localparam int N_BITS   = 4;
    localparam int AVG_LOG2 = 2;

    typedef struct {
        int       cyc;
        bit [3:0] code;
        bit       orng;
        bit       berr;
    } code_exp_t;

    typedef struct {
        int       cyc;
        bit [3:0] code;
    } avg_exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    code_exp_t cq[$];
    avg_exp_t  aq[$];

    flash_encoder_sync_if #(.N_BITS(N_BITS)) bus ();

    flash_encoder_sync #(.N_BITS(N_BITS), .AVG_LOG2(AVG_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.code_valid) begin
                if (cq.size() == 0) begin
                    check("unexpected_code_valid", 1, 0);
                end else begin
                    code_exp_t e;
                    e = cq.pop_front();
                    check("code_cycle", cyc, e.cyc);
                    check("code", int'(bus.code), int'(e.code));
                    check("over_range", int'(bus.over_range), int'(e.orng));
                    check("bubble_err", int'(bus.bubble_err), int'(e.berr));
                end
            end
            if (bus.avg_valid) begin
                if (aq.size() == 0) begin
                    check("unexpected_avg_valid", 1, 0);
                end else begin
                    avg_exp_t a;
                    a = aq.pop_front();
                    check("avg_cycle", cyc, a.cyc);
                    check("avg_code", int'(bus.avg_code), int'(a.code));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle; the result must appear two cycles later
    task automatic sample(input logic [15:0] t, input bit [3:0] ec, input bit eo, input bit eb);
        code_exp_t e;
        e.cyc  = cyc + 2;
        e.code = ec;
        e.orng = eo;
        e.berr = eb;
        cq.push_back(e);
        bus.sample_en = 1'b1;
        bus.therm     = t;
        tick();
        bus.sample_en = 1'b0;
    endtask

    // Average expected one cycle after the code_valid of a sample issued on cycle issue_cyc
    task automatic expect_avg(input int issue_cyc, input bit [3:0] v);
        avg_exp_t a;
        a.cyc  = issue_cyc + 3;
        a.code = v;
        aq.push_back(a);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (cq.size() != 0 || aq.size() != 0); i++) begin
            tick();
        end
        check("code_queue_drained", cq.size(), 0);
        check("avg_queue_drained", aq.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, int'(bus.code), 0);
        check({tag, "_code_valid"}, int'(bus.code_valid), 0);
        check({tag, "_over_range"}, int'(bus.over_range), 0);
        check({tag, "_bubble_err"}, int'(bus.bubble_err), 0);
        check({tag, "_avg_code"}, int'(bus.avg_code), 0);
        check({tag, "_avg_valid"}, int'(bus.avg_valid), 0);
    endtask

    initial begin
        int c0;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.sample_en = 1'b0;
        bus.avg_clear = 1'b0;
        bus.therm     = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Clean, bubbled, isolated-bit and range-end conversions; first four close a window
        c0 = cyc;
        sample(16'h00FF, 4'd7, 1'b0, 1'b0);
        sample(16'h00DF, 4'd7, 1'b0, 1'b1);
        sample(16'h0401, 4'd0, 1'b0, 1'b1);
        expect_avg(cyc, 4'd7);
        sample(16'hFFFF, 4'd15, 1'b1, 1'b0);
        sample(16'h0000, 4'd0, 1'b0, 1'b0);
        sample(16'h0001, 4'd0, 1'b0, 1'b0);
        check("back_to_back_issue", cyc - c0, 6);
        drain();

        // Discard the partial window of two zero codes
        bus.avg_clear = 1'b1;
        tick();
        bus.avg_clear = 1'b0;

        // Codes 3,4,5,6 -> 18>>2 = 4, then 15,15,15,14 -> 59>>2 = 14
        sample(16'h000F, 4'd3, 1'b0, 1'b0);
        sample(16'h001F, 4'd4, 1'b0, 1'b0);
        sample(16'h003F, 4'd5, 1'b0, 1'b0);
        expect_avg(cyc, 4'd4);
        sample(16'h007F, 4'd6, 1'b0, 1'b0);
        sample(16'hFFFF, 4'd15, 1'b1, 1'b0);
        sample(16'hFFFF, 4'd15, 1'b1, 1'b0);
        sample(16'hFFFF, 4'd15, 1'b1, 1'b0);
        expect_avg(cyc, 4'd14);
        sample(16'h7FFF, 4'd14, 1'b0, 1'b0);
        drain();

        // Two samples, then a clear coincident with the third result; window completes 3 later
        sample(16'h0003, 4'd1, 1'b0, 1'b0);
        sample(16'h0007, 4'd2, 1'b0, 1'b0);
        sample(16'h01FF, 4'd8, 1'b0, 1'b0);
        tick();
        bus.avg_clear = 1'b1;
        tick();
        bus.avg_clear = 1'b0;
        sample(16'h03FF, 4'd9, 1'b0, 1'b0);
        tick();
        sample(16'h07FF, 4'd10, 1'b0, 1'b0);
        tick();
        tick();
        expect_avg(cyc, 4'd9);
        sample(16'h0FFF, 4'd11, 1'b0, 1'b0);
        drain();

        // Half-full window plus samples in flight, then a one-cycle reset
        sample(16'h003F, 4'd5, 1'b0, 1'b0);
        sample(16'h003F, 4'd5, 1'b0, 1'b0);
        drain();
        bus.sample_en = 1'b1;
        bus.therm     = 16'h00FF;
        tick();
        bus.therm     = 16'h01FF;
        rst_n         = 1'b0;
        cq.delete();
        aq.delete();
        tick();
        bus.sample_en = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        tick();
        repeat (4) tick();

        // First full window after reset: 1,2,3,4 -> 10>>2 = 2
        sample(16'h0003, 4'd1, 1'b0, 1'b0);
        sample(16'h0007, 4'd2, 1'b0, 1'b0);
        sample(16'h000F, 4'd3, 1'b0, 1'b0);
        expect_avg(cyc, 4'd2);
        sample(16'h001F, 4'd4, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
